// File: rtl/mmr_voted_register_pkg.sv
// mmr_pkg: voting-scheme constants, majority helper and parameter legality check
package mmr_pkg;
  localparam int VOTE_NONE = 0;
  localparam int VOTE_SINGLE = 1;
  localparam int VOTE_SKEW = 2;
  localparam int VOTE_FULL = 3;
  localparam int MAX_K = 32;
  function automatic logic maj(input logic [MAX_K-1:0] v, input int k);
    int ones;
    ones = 0;
    for (int i = 0; i < k; i++) ones += int'(v[i]);
    return ones > k / 2;
  endfunction
  function automatic bit params_ok(input int k, input int kc, input int vs);
    return vs >= VOTE_NONE && vs <= VOTE_FULL && k >= 1 && k <= MAX_K &&
           (kc == 1 || kc == k) && (vs == VOTE_NONE || (k >= 3 && k % 2 == 1));
  endfunction
endpackage

// File: rtl/mmr_majority_voter.sv
// mmr_majority_voter: K-input majority vote over the replica bits
module mmr_majority_voter
  import mmr_pkg::*;
#(
  parameter int K = 3
) (
  input  logic d_i [K-1:0],
  output logic q_o
);
  logic [MAX_K-1:0] v;
  always_comb begin
    v = '0;
    for (int i = 0; i < K; i++) v[i] = d_i[i];
    q_o = maj(v, K);
  end
endmodule

// File: rtl/mmr_voted_register.sv
// mmr_voted_register: K-way redundant single-bit register with selectable voting and disagreement flag
module mmr_voted_register
  import mmr_pkg::*;
#(
  parameter int   K_MMR         = 3,
  parameter int   K_MMR_CLOCK   = 1,
  parameter bit   MISMATCH_EN   = 1'b1,
  parameter int   VOTING_SCHEME = 3,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic [K_MMR_CLOCK-1:0] clk_i,
  input  logic                   rst_i,
  input  logic                   D_i [K_MMR-1:0],
  output logic                   Q_o [K_MMR-1:0],
  output logic                   mismatch_o
);
  localparam int NR = (VOTING_SCHEME == VOTE_NONE) ? 1 : K_MMR;
  localparam int NV = (VOTING_SCHEME == VOTE_FULL) ? K_MMR : 1;
  logic r [NR-1:0];
  (* keep = "true", dont_touch = "true" *) logic vote [NV-1:0];
  logic diff;
  if (!params_ok(K_MMR, K_MMR_CLOCK, VOTING_SCHEME)) begin : g_bad_params
    $error("mmr_voted_register: illegal K_MMR / K_MMR_CLOCK / VOTING_SCHEME combination");
  end
  for (genvar k = 0; k < NR; k++) begin : g_rep
    localparam int CI = (K_MMR_CLOCK == K_MMR) ? k : 0;
    logic r_d;
    (* keep = "true", dont_touch = "true" *) logic r_q;
    always_comb r_d = D_i[k];
    always_ff @(posedge clk_i[CI]) begin
      if (rst_i) r_q <= RESET_VALUE;
      else r_q <= r_d;
    end
    assign r[k] = r_q;
  end
  if (VOTING_SCHEME == VOTE_NONE) begin : g_none
    assign vote[0] = r[0];
  end else if (VOTING_SCHEME == VOTE_FULL) begin : g_full
    for (genvar k = 0; k < K_MMR; k++) begin : g_v
      mmr_majority_voter #(.K(K_MMR)) u_voter (.d_i(r), .q_o(vote[k]));
    end
  end else begin : g_one
    mmr_majority_voter #(.K(K_MMR)) u_voter (.d_i(r), .q_o(vote[0]));
  end
  for (genvar k = 0; k < K_MMR; k++) begin : g_out
    if (VOTING_SCHEME == VOTE_FULL) begin : g_full
      assign Q_o[k] = vote[k];
    end else if (VOTING_SCHEME == VOTE_SKEW && k > 0) begin : g_skew
      assign Q_o[k] = r[k-1];
    end else begin : g_shared
      assign Q_o[k] = vote[0];
    end
  end
  // any replica differing from replica 0 means they are not all equal
  always_comb begin
    diff = 1'b0;
    for (int k = 1; k < NR; k++) diff = diff | (r[k] != r[0]);
  end
  assign mismatch_o = MISMATCH_EN && (VOTING_SCHEME != VOTE_NONE) && diff;
endmodule

// File: tb/tb_mmr_voted_register.sv
// tb_mmr_voted_register: scoreboard bench over K=3/5, all schemes, mismatch-off and per-replica-clock builds
module tb_mmr_voted_register;
  logic clk = 1'b0;
  logic rst;
  logic d5 [4:0];
  logic d3 [2:0];
  logic [3:0][4:0] q5;
  logic [3:0] m5;
  logic [3:0][2:0] q3;
  logic [3:0] m3;
  logic o5n [4:0];
  logic o5c [4:0];
  logic [4:0] q5n, q5c;
  logic m5n, m5c;
  int errors = 0;
  int checks = 0;
  typedef struct packed {
    logic [3:0][4:0] q5;
    logic [3:0]      m5;
    logic [3:0][2:0] q3;
    logic [3:0]      m3;
    logic [4:0]      q5n;
    logic            m5n;
    logic [4:0]      q5c;
    logic            m5c;
  } exp_t;
  exp_t sb [$];
  always #5 clk = ~clk;
  for (genvar s = 0; s < 4; s++) begin : g_s
    logic o5 [4:0];
    logic o3 [2:0];
    mmr_voted_register #(.K_MMR(5), .VOTING_SCHEME(s)) u5 (
      .clk_i(clk), .rst_i(rst), .D_i(d5), .Q_o(o5), .mismatch_o(m5[s]));
    mmr_voted_register #(.K_MMR(3), .VOTING_SCHEME(s)) u3 (
      .clk_i(clk), .rst_i(rst), .D_i(d3), .Q_o(o3), .mismatch_o(m3[s]));
    for (genvar k = 0; k < 5; k++) begin : g_k5
      assign q5[s][k] = o5[k];
    end
    for (genvar k = 0; k < 3; k++) begin : g_k3
      assign q3[s][k] = o3[k];
    end
  end
  mmr_voted_register #(.K_MMR(5), .VOTING_SCHEME(1), .MISMATCH_EN(1'b0)) u5n (
    .clk_i(clk), .rst_i(rst), .D_i(d5), .Q_o(o5n), .mismatch_o(m5n));
  mmr_voted_register #(.K_MMR(5), .K_MMR_CLOCK(5), .VOTING_SCHEME(2)) u5c (
    .clk_i({5{clk}}), .rst_i(rst), .D_i(d5), .Q_o(o5c), .mismatch_o(m5c));
  for (genvar k = 0; k < 5; k++) begin : g_pk
    assign q5n[k] = o5n[k];
    assign q5c[k] = o5c[k];
  end
  function automatic logic [4:0] model_q(input int s, input int n, input logic [4:0] r);
    logic [4:0] q;
    logic v;
    int ones;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(r[i]);
    v = (ones * 2 > n);
    q = '0;
    for (int k = 0; k < n; k++) q[k] = (s == 0) ? r[0] : (s == 2 && k > 0) ? r[k-1] : v;
    return q;
  endfunction
  function automatic logic model_m(input int s, input int n, input logic [4:0] r);
    logic [4:0] m;
    m = 5'((1 << n) - 1);
    return s != 0 && (r & m) != 5'd0 && (r & m) != m;
  endfunction
  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask
  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("k5_s%0d_q", s), q5[s], e.q5[s]);
      chk($sformatf("k5_s%0d_mm", s), 5'(m5[s]), 5'(e.m5[s]));
      chk($sformatf("k3_s%0d_q", s), 5'(q3[s]), 5'(e.q3[s]));
      chk($sformatf("k3_s%0d_mm", s), 5'(m3[s]), 5'(e.m3[s]));
    end
    chk("k5_nomm_q", q5n, e.q5n);
    chk("k5_nomm_mm", 5'(m5n), 5'(e.m5n));
    chk("k5_mclk_q", q5c, e.q5c);
    chk("k5_mclk_mm", 5'(m5c), 5'(e.m5c));
  endtask
  task automatic step(input logic r_in, input logic [4:0] v);
    exp_t e;
    logic [4:0] r5, r3, t;
    rst = r_in;
    for (int k = 0; k < 5; k++) d5[k] = v[k];
    for (int k = 0; k < 3; k++) d3[k] = v[k];
    r5 = r_in ? 5'b0 : v;
    r3 = r_in ? 5'b0 : {2'b0, v[2:0]};
    for (int s = 0; s < 4; s++) begin
      e.q5[s] = model_q(s, 5, r5);
      e.m5[s] = model_m(s, 5, r5);
      t = model_q(s, 3, r3);
      e.q3[s] = t[2:0];
      e.m3[s] = model_m(s, 3, r3);
    end
    e.q5n = model_q(1, 5, r5);
    e.m5n = 1'b0;
    e.q5c = model_q(2, 5, r5);
    e.m5c = model_m(2, 5, r5);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare();
  endtask
  initial begin
    repeat (3) step(1'b1, 5'h1f);
    step(1'b0, 5'h1f);
    step(1'b0, 5'h00);
    step(1'b0, 5'h1f);
    step(1'b0, 5'h00);
    step(1'b0, 5'b00111);
    step(1'b0, 5'b00001);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 5'(i));
      step(1'b0, 5'h00);
    end
    step(1'b0, 5'h1f);
    step(1'b1, 5'h1f);
    step(1'b0, 5'h15);
    step(1'b0, 5'h0a);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mmr_voted_register.md
# mmr_voted_register

Parameterised K-modular-redundant (K_MMR-way) single-bit register with configurable majority voting and a replica-disagreement flag. It is the basic storage cell for radiation-hardened control logic: each replica captures its own input bit, and the outputs come from the voted or raw replica state according to VOTING_SCHEME. It is instantiated wherever a TMR or 5MR flop is needed, with single or per-replica clock trees.

## Interface
- K_MMR, default 3: number of replicas. Must be odd and ≥3, except under scheme 0, where any value ≥1 is allowed.
- K_MMR_CLOCK, default 1: width of the clock vector. Must be 1 or K_MMR.
- MISMATCH_EN, default 1: enables mismatch detection. When 0, mismatch_o is tied to 0.
- VOTING_SCHEME, default 3: selects one of the output schemes 0, 1, 2 or 3 (see Operation).
- RESET_VALUE, default 0: the value loaded into every replica on reset.
- clk_i input [K_MMR_CLOCK-1:0]: one clock. All bits are branches of the same clock, so there is a single clock domain. Replica k uses clk_i[k] when K_MMR_CLOCK==K_MMR, otherwise clk_i[0].
- rst_i input 1: reset, synchronous and active-high.
- D_i input unpacked logic [K_MMR-1:0]: per-replica data inputs.
- Q_o output unpacked logic [K_MMR-1:0]: per-replica outputs.
- mismatch_o output 1: replicas disagree.

## Operation
- Replica register r[k] on the rising clock edge:
  - rst_i=1: r[k] <= RESET_VALUE.
  - Otherwise: r[k] <= D_i[k].
- maj(r) = 1 when more than K_MMR/2 of r are 1 (2 of 3, 3 of 5).
- Scheme 0, no voting: only one register r[0], fed from D_i[0]. Every Q_o[k] = r[0]. D_i[k>0] are ignored. mismatch_o = 0.
- Scheme 1, one voter: every Q_o[k] = maj(r).
- Scheme 2, one voter with skew: Q_o[0] = maj(r), and Q_o[k] = r[k-1] for k = 1..K_MMR-1.
- Scheme 3, K_MMR voters: Q_o[k] = maj_k(r), using K_MMR separate voter instances with identical logic.
- mismatch_o:
  - Equals MISMATCH_EN && !(all r[k] equal).
  - It is combinational from the replica registers and is not registered.
  - Under scheme 0 it is always 0.
- Voters and the mismatch logic must not be merged or optimised across replicas. Apply keep/dont_touch attributes to r[k] and to the voter outputs.

## Timing
- Latency from D_i to Q_o is 1 cycle, with no additional pipeline stage.
- Reset is synchronous: the cycle after rst_i=1 is sampled, every Q_o = RESET_VALUE and mismatch_o = 0.
- Reset asserted mid-operation overrides D_i on that same edge.
- Q_o and mismatch_o change only after a clock edge. No output depends combinationally on D_i or rst_i.
- There is no handshake: new data is captured every cycle.

## Structure
- Shared package mmr_pkg:
  - Voting-scheme constants VOTE_NONE=0, VOTE_SINGLE=1, VOTE_SKEW=2, VOTE_FULL=3.
  - A majority function parameterised on K.
  - Elaboration-time checks: K_MMR odd, K_MMR_CLOCK ∈ {1, K_MMR}, VOTING_SCHEME ≤ 3.
- Sub-module mmr_majority_voter:
  - Parameter K.
  - Input unpacked [K-1:0]; output 1 bit.
  - Instantiated once for schemes 1 and 2, K_MMR times for scheme 3.

## Test plan
- Reset, with RESET_VALUE=0 and K_MMR=5:
  - Hold rst_i=1 for 3 cycles with D_i all 1 → all Q_o=0 and mismatch_o=0 in every scheme.
  - Deassert reset → Q_o=1 one cycle later.
- All-ones then all-zeros, with K_MMR=3 and 5 across schemes 0–3:
  - D_i all 1 → every Q_o=1 after 1 cycle.
  - D_i all 0 → every Q_o=0 after 1 cycle.
  - mismatch_o stays 0 throughout.
- Minority upset, with K_MMR=5 and D_i=5'b00111 (bits 0–2 high):
  - Scheme 1 and scheme 3 → all Q_o=1, mismatch_o=1.
  - Scheme 0 → all Q_o=1 (r[0]=1), mismatch_o=0.
- Scheme 2 skew, with K_MMR=3 and D_i=3'b001 → Q_o[0]=0 (voted), Q_o[1]=1 (r[0]), Q_o[2]=0 (r[1]), mismatch_o=1.
- Exhaustive sweep with K_MMR=5:
  - For i = 0..31, apply D_i=i, then zeros.
  - Each Q_o must match the scheme formula against a reference model delayed by 1 cycle.
  - mismatch_o=1 for every i except 0 and 31.
  - Run with MISMATCH_EN=0 → mismatch_o remains 0.
- Multi-clock build, with K_MMR_CLOCK=K_MMR and all clk_i bits tied to one clock → bit-identical results to the K_MMR_CLOCK=1 build.
